// File: rtl/risc_ctrl_pkg.sv
// Shared encodings for the RiSC-16 multicycle control sequencer.
package risc_ctrl_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned REG_AW  = 3;
    localparam int unsigned RET_W   = 16;
    localparam int unsigned STATE_W = 3;

    // IR field slice positions
    localparam int unsigned OP_MSB   = 15;
    localparam int unsigned OP_LSB   = 13;
    localparam int unsigned RA_MSB   = 12;
    localparam int unsigned RA_LSB   = 10;
    localparam int unsigned RB_MSB   = 9;
    localparam int unsigned RB_LSB   = 7;
    localparam int unsigned IMM7_MSB = 6;
    localparam int unsigned IMM7_LSB = 0;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADDI = 3'b001,
        OP_NAND = 3'b010,
        OP_LUI  = 3'b011,
        OP_SW   = 3'b100,
        OP_LW   = 3'b101,
        OP_BEQ  = 3'b110,
        OP_JALR = 3'b111
    } opcode_t;

    // Sequencer states
    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_FETCH  = 3'd1;
    localparam logic [STATE_W-1:0] S_DECODE = 3'd2;
    localparam logic [STATE_W-1:0] S_EXEC   = 3'd3;
    localparam logic [STATE_W-1:0] S_MEM    = 3'd4;
    localparam logic [STATE_W-1:0] S_WB     = 3'd5;
    localparam logic [STATE_W-1:0] S_HALT   = 3'd6;

    // ALU operation select
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_NAND = 2'b01;
    localparam logic [1:0] ALU_EQ   = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    // Mux sources
    localparam logic A_REGB    = 1'b0;
    localparam logic A_IMM10   = 1'b1;
    localparam logic B_REG     = 1'b0;
    localparam logic B_IMM7    = 1'b1;
    localparam logic MADDR_PC  = 1'b0;
    localparam logic MADDR_ALU = 1'b1;

    localparam logic [1:0] WSEL_ALU = 2'd0;
    localparam logic [1:0] WSEL_MEM = 2'd1;
    localparam logic [1:0] WSEL_PC  = 2'd2;

    localparam logic [1:0] PC_INC = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_REG = 2'd2;

    function automatic opcode_t ir_op(input logic [INSTR_W-1:0] ir);
        return opcode_t'(ir[OP_MSB:OP_LSB]);
    endfunction

    function automatic logic [REG_AW-1:0] ir_ra(input logic [INSTR_W-1:0] ir);
        return ir[RA_MSB:RA_LSB];
    endfunction

    // Opcode 111 with a non-zero immediate is HALT; with imm7 = 0 it is JALR
    function automatic logic ir_is_halt(input logic [INSTR_W-1:0] ir);
        return (ir[OP_MSB:OP_LSB] == 3'b111) && (ir[IMM7_MSB:IMM7_LSB] != 7'd0);
    endfunction

endpackage

// File: rtl/risc_ctrl_decode.sv
// Combinational control decoder: {state, IR, alu_eq} -> datapath controls.
module risc_ctrl_decode
    import risc_ctrl_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic [INSTR_W-1:0] ir,
    input  logic               alu_eq,
    output logic [1:0]         alu_sel,
    output logic               alu_a_sel,
    output logic               alu_b_sel,
    output logic               reg_we,
    output logic [REG_AW-1:0]  reg_waddr,
    output logic [1:0]         reg_wsel,
    output logic               pc_we,
    output logic [1:0]         pc_sel,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_addr_sel,
    output logic               busy,
    output logic               halted
);

    opcode_t           op;
    logic [REG_AW-1:0] ra;
    logic              ra_writable;
    logic [1:0]        op_alu;
    logic              op_a;
    logic              op_b;
    logic              unused_rb;

    assign op          = ir_op(ir);
    assign ra          = ir_ra(ir);
    assign ra_writable = (ra != REG_AW'(0));
    assign unused_rb   = ^ir[RB_MSB:RB_LSB];

    // Per-opcode ALU setup; held through MEM/WB so the combinational result stays valid
    always_comb begin
        op_alu = ALU_ADD;
        op_a   = A_REGB;
        op_b   = B_REG;
        case (op)
            OP_ADD:  op_alu = ALU_ADD;
            OP_ADDI: op_b   = B_IMM7;
            OP_NAND: op_alu = ALU_NAND;
            OP_LUI: begin
                op_alu = ALU_PASS;
                op_a   = A_IMM10;
            end
            OP_SW, OP_LW: op_b = B_IMM7;
            OP_BEQ:  op_alu = ALU_EQ;
            default: op_alu = ALU_ADD;
        endcase
    end

    // Phase decode of all datapath enables
    always_comb begin
        alu_sel      = ALU_ADD;
        alu_a_sel    = A_REGB;
        alu_b_sel    = B_REG;
        reg_we       = 1'b0;
        reg_waddr    = ra;
        reg_wsel     = WSEL_ALU;
        pc_we        = 1'b0;
        pc_sel       = PC_INC;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = MADDR_PC;
        busy         = 1'b0;
        halted       = 1'b0;
        case (state)
            S_FETCH: begin
                busy         = 1'b1;
                mem_req      = 1'b1;
                mem_addr_sel = MADDR_PC;
            end
            S_DECODE: begin
                busy   = 1'b1;
                pc_we  = 1'b1;
                pc_sel = PC_INC;
            end
            S_EXEC: begin
                busy      = 1'b1;
                alu_sel   = op_alu;
                alu_a_sel = op_a;
                alu_b_sel = op_b;
                if (op == OP_BEQ && alu_eq) begin
                    pc_we  = 1'b1;
                    pc_sel = PC_BR;
                end
                if (op == OP_JALR) begin
                    pc_we    = 1'b1;
                    pc_sel   = PC_REG;
                    reg_we   = ra_writable;
                    reg_wsel = WSEL_PC;
                end
            end
            S_MEM: begin
                busy         = 1'b1;
                alu_sel      = op_alu;
                alu_a_sel    = op_a;
                alu_b_sel    = op_b;
                mem_req      = 1'b1;
                mem_addr_sel = MADDR_ALU;
                mem_we       = (op == OP_SW);
            end
            S_WB: begin
                busy      = 1'b1;
                alu_sel   = op_alu;
                alu_a_sel = op_a;
                alu_b_sel = op_b;
                reg_we    = ra_writable;
                reg_wsel  = (op == OP_LW) ? WSEL_MEM : WSEL_ALU;
            end
            S_HALT: halted = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: rtl/risc_ctrl_fsm.sv
// RiSC-16 multicycle control sequencer: state register, IR, retire counter.
module risc_ctrl_fsm
    import risc_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    input  logic               mem_ack,
    input  logic               alu_eq,
    output logic [1:0]         alu_sel,
    output logic               alu_a_sel,
    output logic               alu_b_sel,
    output logic               reg_we,
    output logic [REG_AW-1:0]  reg_waddr,
    output logic [1:0]         reg_wsel,
    output logic               pc_we,
    output logic [1:0]         pc_sel,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_addr_sel,
    output logic               busy,
    output logic               halted,
    output logic [RET_W-1:0]   retired
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic [INSTR_W-1:0] ir;
    logic               retire;
    opcode_t            op;

    assign op = ir_op(ir);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Instruction register and retired-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ir      <= '0;
            retired <= '0;
        end else begin
            if (state == S_FETCH && mem_ack) begin
                ir <= instr;
            end
            if (retire) begin
                retired <= retired + RET_W'(1);
            end
        end
    end

    // Next-state and retire decision
    always_comb begin
        next_state = state;
        retire     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (ir_is_halt(ir)) begin
                    next_state = S_HALT;
                    retire     = 1'b1;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_ADD, OP_ADDI, OP_NAND, OP_LUI: next_state = S_WB;
                    OP_SW, OP_LW: next_state = S_MEM;
                    default: begin
                        next_state = S_FETCH;
                        retire     = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (op == OP_LW) begin
                        next_state = S_WB;
                    end else begin
                        next_state = S_FETCH;
                        retire     = 1'b1;
                    end
                end
            end
            S_WB: begin
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            S_HALT: next_state = S_HALT;
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode from state and IR
    risc_ctrl_decode u_decode (
        .state        (state),
        .ir           (ir),
        .alu_eq       (alu_eq),
        .alu_sel      (alu_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .reg_we       (reg_we),
        .reg_waddr    (reg_waddr),
        .reg_wsel     (reg_wsel),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .busy         (busy),
        .halted       (halted)
    );

endmodule
